// File: rtl/reset_sequencer.sv
// reset_sequencer: internal reset generator.
// Merges synchronised buttons, idle-mode detect and (optionally) a watchdog
// into one reset request, stretches it, then releases NUM_DOMAINS active-low
// domain resets one after another. cause_o reports why the last reset happened.
// Optional watchdog: define RESET_SEQ_WATCHDOG_EN to add kick_i and the
// watchdog counter; otherwise cause_o[2] is always 0.
//
// state      | meaning
// ST_ASSERT  | request active, every domain held in reset
// ST_HOLD    | request gone, stretching for STRETCH_CYCLES
// ST_RELEASE | releasing domains 1..NUM_DOMAINS-1, STAGGER_CYCLES apart
// ST_RUN     | all domains out of reset
module reset_sequencer #(
   parameter int NUM_BUTTONS    = 4,
   parameter int MODE_W         = 2,
   parameter int IDLE_MODE      = 0,
   parameter int NUM_DOMAINS    = 3,
   parameter int STRETCH_CYCLES = 16,
   parameter int STAGGER_CYCLES = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int WDOG_CYCLES    = 100
) (
   input  logic                   clock_i,
   input  logic                   reset_ni,
   input  logic [MODE_W-1:0]      mode_i,
   input  logic [NUM_BUTTONS-1:0] buttons_i,
`ifdef RESET_SEQ_WATCHDOG_EN
   input  logic                   kick_i,
`endif
   output logic [NUM_DOMAINS-1:0] reset_o,
   output logic                   busy_o,
   output logic [2:0]             cause_o
);

   localparam int CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int DOM_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_TC  = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [DOM_W-1:0] DOM_LAST = DOM_W'(NUM_DOMAINS - 1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   state_t                              r_state;
   state_t                              w_state_nxt;
   logic [CNT_W-1:0]                    r_cnt;
   logic [CNT_W-1:0]                    w_cnt_nxt;
   logic [DOM_W-1:0]                    r_dom;
   logic [DOM_W-1:0]                    w_dom_nxt;
   logic [SYNC_STAGES-1:0][NUM_BUTTONS-1:0] r_sync;
   logic                                w_btn_req;
   logic                                w_idle_req;
   logic                                w_wdog_fire;
   logic [2:0]                          w_req_bits;
   logic                                w_req;
   logic                                w_hold_tc;
   logic                                w_rel_tc;
   logic [NUM_DOMAINS-1:0]              w_reset_nxt;
   logic                                w_busy_nxt;
   logic [2:0]                          w_cause_nxt;

   // Button synchroniser: stage 0 samples the raw pins, last stage feeds the request.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) r_sync <= '0;
      else           r_sync <= {r_sync[SYNC_STAGES-2:0], buttons_i};
   end

   assign w_btn_req  = |r_sync[SYNC_STAGES-1];
   assign w_idle_req = (mode_i == MODE_W'(IDLE_MODE));

`ifdef RESET_SEQ_WATCHDOG_EN
   localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [WDOG_W-1:0] WDOG_TC = WDOG_W'(WDOG_CYCLES - 1);

   logic [WDOG_W-1:0] r_wdog_cnt;

   assign w_wdog_fire = (r_state == ST_RUN) && !kick_i && (r_wdog_cnt == WDOG_TC);

   // Watchdog only runs in ST_RUN; a kick or leaving ST_RUN clears it.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni)                            r_wdog_cnt <= '0;
      else if ((r_state != ST_RUN) || kick_i)   r_wdog_cnt <= '0;
      else if (r_wdog_cnt != WDOG_TC)           r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
   end
`else
   assign w_wdog_fire = 1'b0;
`endif

   assign w_req_bits = {w_wdog_fire, w_idle_req, w_btn_req};
   assign w_req      = |w_req_bits;
   // A request on a terminal-count edge wins: both tc flags require !w_req.
   assign w_hold_tc  = (r_state == ST_HOLD)    && !w_req && (r_cnt == HOLD_TC);
   assign w_rel_tc   = (r_state == ST_RELEASE) && !w_req && (r_cnt == STAG_TC);

   // State register with the stretch/stagger counter and next-domain index.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state <= ST_ASSERT;
         r_cnt   <= '0;
         r_dom   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dom   <= w_dom_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_dom_nxt   = r_dom;
      case (r_state)
         ST_ASSERT: begin
            w_cnt_nxt = '0;
            if (!w_req) w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (w_req) begin
               w_state_nxt = ST_ASSERT;
               w_cnt_nxt   = '0;
            end else if (w_hold_tc) begin
               w_cnt_nxt   = '0;
               w_dom_nxt   = DOM_W'(1);
               w_state_nxt = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            if (w_req) begin
               w_state_nxt = ST_ASSERT;
               w_cnt_nxt   = '0;
            end else if (w_rel_tc) begin
               w_cnt_nxt   = '0;
               w_dom_nxt   = r_dom + DOM_W'(1);
               if (r_dom == DOM_LAST) w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_RUN: begin
            w_cnt_nxt = '0;
            if (w_req) w_state_nxt = ST_ASSERT;
         end
         default: begin
            w_state_nxt = ST_ASSERT;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Output logic: next values of the registered reset, busy and cause outputs.
   always_comb begin
      w_reset_nxt = reset_o;
      w_busy_nxt  = (w_state_nxt != ST_RUN);
      w_cause_nxt = cause_o;
      if (w_state_nxt == ST_ASSERT) begin
         w_reset_nxt = '0;
         if (r_state == ST_ASSERT) w_cause_nxt = cause_o | w_req_bits;
         else                      w_cause_nxt = w_req_bits;
      end else if (w_state_nxt == ST_RUN) begin
         w_reset_nxt = '1;
      end else if (w_hold_tc) begin
         w_reset_nxt[0] = 1'b1;
      end else if (w_rel_tc) begin
         w_reset_nxt[r_dom] = 1'b1;
      end
   end

   // Output registers; no input reaches an output without passing a flop.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         reset_o <= '0;
         busy_o  <= 1'b1;
         cause_o <= '0;
      end else begin
         reset_o <= w_reset_nxt;
         busy_o  <= w_busy_nxt;
         cause_o <= w_cause_nxt;
      end
   end

endmodule
